pipe_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage pipeline. It detects load-use hazards, resolves taken branches in MEM (from the EX/MEM branch/zero bits), and handshakes data-memory accesses from the EX/MEM stage. It drives the PC-write, IF/ID-write, bubble, flush and hold controls of the IF/ID, ID/EX and EX/MEM buffers, and keeps saturating stall/flush counters for debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status inputs and the stall/flush/hold controls it drives.
// The master modport is the controller; the slave modport is the pipeline side.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned REG_W = 5;

    logic             id_ex_memread;
    logic [REG_W-1:0] id_ex_rd;
    logic [REG_W-1:0] if_id_rs1;
    logic [REG_W-1:0] if_id_rs2;
    logic             ex_mem_branch;
    logic             ex_mem_zero;
    logic             ex_mem_memread;
    logic             ex_mem_memwrite;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             pc_src;
    logic             flush;
    logic             pipe_hold;
    logic             dmem_req;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
        input  ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite,
        input  dmem_ready,
        output pc_write, if_id_write, id_ex_bubble, pc_src, flush,
        output pipe_hold, dmem_req, mem_error, stall_cnt, flush_cnt
    );

    modport slave (
        output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
        output ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite,
        output dmem_ready,
        input  pc_write, if_id_write, id_ex_bubble, pc_src, flush,
        input  pipe_hold, dmem_req, mem_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, taken-branch flushes in MEM,
// data-memory wait handshaking with timeout, and saturating stall/flush debug counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.master  hz
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_error_q;
    logic              mem_error_nxt;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic memop;
    logic taken;
    logic load_use;

    logic pc_write_c;
    logic if_id_write_c;
    logic id_ex_bubble_c;
    logic pc_src_c;
    logic flush_c;
    logic pipe_hold_c;
    logic dmem_req_c;

    // Hazard detection; a branch that is also a memory op is treated as a memory op only
    assign memop    = hz.ex_mem_memread | hz.ex_mem_memwrite;
    assign taken    = hz.ex_mem_branch & hz.ex_mem_zero & ~memop;
    assign load_use = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                      ((hz.id_ex_rd == hz.if_id_rs1) || (hz.id_ex_rd == hz.if_id_rs2));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_error_q <= mem_error_nxt;
        end
    end

    // Next-state and raw control decode
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        mem_error_nxt  = mem_error_q;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        pc_src_c       = 1'b0;
        flush_c        = 1'b0;
        pipe_hold_c    = 1'b0;
        dmem_req_c     = 1'b0;

        case (state)
            IDLE: begin
                if (memop) begin
                    dmem_req_c = 1'b1;
                    if (hz.dmem_ready) begin
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                    end else begin
                        pipe_hold_c  = 1'b1;
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end
                end else if (taken) begin
                    pc_src_c      = 1'b1;
                    flush_c       = 1'b1;
                    pc_write_c    = 1'b1;
                    if_id_write_c = 1'b1;
                end else if (load_use) begin
                    id_ex_bubble_c = 1'b1;
                end else begin
                    pc_write_c    = 1'b1;
                    if_id_write_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                dmem_req_c  = 1'b1;
                pipe_hold_c = 1'b1;
                // Completion beats a coincident timeout
                if (hz.dmem_ready) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    mem_error_nxt = 1'b1;
                    state_nxt     = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            ERROR: begin
                pipe_hold_c = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Saturating debug counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_c && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_c && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // Reset forces every control low asynchronously, including the enables
    assign hz.pc_write     = pc_write_c     & ~reset;
    assign hz.if_id_write  = if_id_write_c  & ~reset;
    assign hz.id_ex_bubble = id_ex_bubble_c & ~reset;
    assign hz.pc_src       = pc_src_c       & ~reset;
    assign hz.flush        = flush_c        & ~reset;
    assign hz.pipe_hold    = pipe_hold_c    & ~reset;
    assign hz.dmem_req     = dmem_req_c     & ~reset;
    assign hz.mem_error    = mem_error_q;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;
endmodule
